// File: rtl/argmax_classifier.sv
// argmax_classifier: captures the FC-layer class scores on the rising edge of
// Input_Valid, scans them one compare per cycle and reports the index and value
// of the largest score (lowest index wins ties).
module argmax_classifier #(
    parameter int unsigned NUM_CLASSES    = 10,
    parameter bit          SIGNED_COMPARE = 1'b1
) (
    input  logic        Clock,
    input  logic        Input_Reset,
    input  logic [31:0] Input_0,
    input  logic [31:0] Input_1,
    input  logic [31:0] Input_2,
    input  logic [31:0] Input_3,
    input  logic [31:0] Input_4,
    input  logic [31:0] Input_5,
    input  logic [31:0] Input_6,
    input  logic [31:0] Input_7,
    input  logic [31:0] Input_8,
    input  logic [31:0] Input_9,
    input  logic        Input_Valid,
    input  logic        Input_Finish,
    output logic [3:0]  Output_Class,
    output logic [31:0] Output_Score,
    output logic        Output_Valid,
    output logic        Output_Finish,
    output logic        Busy
);

    localparam int unsigned SCORE_W  = 32;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned MAX_IN   = 10;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic                 valid_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     best_idx_q;
    logic [SCORE_W-1:0]   best_q;
    logic [SCORE_W-1:0]   buf_q [NUM_CLASSES];
    logic [SCORE_W-1:0]   in_w  [MAX_IN];
    logic                 start_c;
    logic                 unused_finish;

    // Input_Finish is informational only; it never steers the scan.
    assign unused_finish = Input_Finish;

    // Gather the score ports into an indexable array.
    assign in_w[0] = Input_0;
    assign in_w[1] = Input_1;
    assign in_w[2] = Input_2;
    assign in_w[3] = Input_3;
    assign in_w[4] = Input_4;
    assign in_w[5] = Input_5;
    assign in_w[6] = Input_6;
    assign in_w[7] = Input_7;
    assign in_w[8] = Input_8;
    assign in_w[9] = Input_9;

    // A scan starts only on a rising edge of Input_Valid seen while idle.
    assign start_c = Input_Valid & ~valid_q & (state_q == IDLE);

    // Strict greater-than keeps the earliest index on ties.
    function automatic logic score_gt(input logic [SCORE_W-1:0] a,
                                      input logic [SCORE_W-1:0] b);
        if (SIGNED_COMPARE) begin
            return $signed(a) > $signed(b);
        end
        return a > b;
    endfunction

    // Capture, sequential scan and registered result outputs.
    always_ff @(posedge Clock) begin
        if (Input_Reset) begin
            state_q       <= IDLE;
            valid_q       <= 1'b0;
            idx_q         <= '0;
            best_idx_q    <= '0;
            best_q        <= '0;
            for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                buf_q[k] <= '0;
            end
            Output_Class  <= '0;
            Output_Score  <= '0;
            Output_Valid  <= 1'b0;
            Output_Finish <= 1'b0;
            Busy          <= 1'b0;
        end else begin
            valid_q      <= Input_Valid;
            Output_Valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        for (int k = 0; k < int'(NUM_CLASSES); k++) begin
                            buf_q[k] <= in_w[k];
                        end
                        best_q     <= in_w[0];
                        best_idx_q <= '0;
                        idx_q      <= IDX_W'(1);
                        state_q    <= SCAN;
                        Busy       <= 1'b1;
                    end
                end
                SCAN: begin
                    if (score_gt(buf_q[idx_q], best_q)) begin
                        best_q     <= buf_q[idx_q];
                        best_idx_q <= idx_q;
                    end
                    idx_q <= idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    Output_Class  <= best_idx_q;
                    Output_Score  <= best_q;
                    Output_Valid  <= 1'b1;
                    Output_Finish <= 1'b1;
                    Busy          <= 1'b0;
                    state_q       <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
